// File: rtl/pe_pkg.sv
// Shared types for the PE row feeder and its scratchpads.
package pe_pkg;

  localparam int PE_DATA_WIDTH = 16;

  typedef logic [PE_DATA_WIDTH-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_F,
    LOAD_I,
    STREAM,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/pe_spad.sv
// Small scratchpad: synchronous write, asynchronous read, contents not reset.
module pe_spad #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // write port: one word per accepted handshake
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pe_row_feeder.sv
// Loads one filter row and one ifmap row, then streams sliding-window
// operand pairs (tap innermost) to a single PE through a registered
// valid/ready output stage.
//
//  state  | meaning
//  IDLE   | waiting for start, cfg sampled here
//  LOAD_F | accepting k filter taps into the filter scratchpad
//  LOAD_I | accepting w ifmap pixels into the ifmap scratchpad
//  STREAM | issuing (w-k+1)*k operand pairs to the PE
//  DONE   | one-cycle done pulse (err too if cfg was illegal)
module pe_row_feeder
  import pe_pkg::*;
#(
  parameter  int DATA_WIDTH = PE_DATA_WIDTH,
  parameter  int MAX_K      = 3,
  parameter  int MAX_W      = 32,
  localparam int KW         = $clog2(MAX_K + 1),
  localparam int WW         = $clog2(MAX_W + 1),
  localparam int FAW        = (MAX_K > 1) ? $clog2(MAX_K) : 1,
  localparam int IAW        = (MAX_W > 1) ? $clog2(MAX_W) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [KW-1:0]         cfg_k,
  input  logic [WW-1:0]         cfg_w,
  input  logic                  fltr_valid,
  output logic                  fltr_ready,
  input  logic [DATA_WIDTH-1:0] fltr_data,
  input  logic                  ifmap_valid,
  output logic                  ifmap_ready,
  input  logic [DATA_WIDTH-1:0] ifmap_data,
  output logic                  pe_valid,
  input  logic                  pe_ready,
  output logic [DATA_WIDTH-1:0] pe_ifmap,
  output logic [DATA_WIDTH-1:0] pe_fltr,
  output logic                  pe_first,
  output logic                  pe_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  feeder_state_t r_state, w_next;

  logic [KW-1:0]         r_k, r_t;
  logic [WW-1:0]         r_w, r_cnt, r_o;
  logic                  r_err, r_fin;
  logic                  r_pe_valid, r_pe_first, r_pe_last;
  logic [DATA_WIDTH-1:0] r_pe_ifmap, r_pe_fltr;

  logic                  w_cfg_ok, w_f_hs, w_i_hs, w_f_end, w_i_end;
  logic                  w_t_last, w_o_last, w_out_hs, w_load;
  logic [IAW-1:0]        w_iaddr;
  logic [FAW-1:0]        w_faddr;
  logic [DATA_WIDTH-1:0] w_irdata, w_frdata;

  assign w_cfg_ok = (cfg_k != '0) && (WW'(cfg_k) <= WW'(MAX_K)) &&
                    (WW'(cfg_k) <= cfg_w) && (cfg_w <= WW'(MAX_W));

  assign w_f_hs   = (r_state == LOAD_F) && fltr_valid;
  assign w_i_hs   = (r_state == LOAD_I) && ifmap_valid;
  assign w_f_end  = w_f_hs && (r_cnt == WW'(r_k) - WW'(1));
  assign w_i_end  = w_i_hs && (r_cnt == r_w - WW'(1));

  assign w_t_last = (r_t == r_k - KW'(1));
  assign w_o_last = (r_o == r_w - WW'(r_k));
  assign w_out_hs = r_pe_valid && pe_ready;
  // refill the output register whenever it is empty or being drained
  assign w_load   = (r_state == STREAM) && !r_fin && (!r_pe_valid || pe_ready);

  assign w_iaddr  = IAW'(r_o + WW'(r_t));
  assign w_faddr  = FAW'(r_t);

  pe_spad #(.DEPTH(MAX_K), .WIDTH(DATA_WIDTH)) u_fspad (
    .clk     (clk),
    .i_we    (w_f_hs),
    .i_waddr (FAW'(r_cnt)),
    .i_wdata (fltr_data),
    .i_raddr (w_faddr),
    .o_rdata (w_frdata)
  );

  pe_spad #(.DEPTH(MAX_W), .WIDTH(DATA_WIDTH)) u_ispad (
    .clk     (clk),
    .i_we    (w_i_hs),
    .i_waddr (IAW'(r_cnt)),
    .i_wdata (ifmap_data),
    .i_raddr (w_iaddr),
    .o_rdata (w_irdata)
  );

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next-state decode and per-state control outputs
  always_comb begin
    w_next      = r_state;
    fltr_ready  = 1'b0;
    ifmap_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = w_cfg_ok ? LOAD_F : DONE;
      end
      LOAD_F: begin
        fltr_ready = 1'b1;
        if (w_f_end) w_next = LOAD_I;
      end
      LOAD_I: begin
        ifmap_ready = 1'b1;
        if (w_i_end) w_next = STREAM;
      end
      STREAM: begin
        if (r_fin && w_out_hs) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        err    = r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // job config, load counter and (o,t) window position
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_k   <= '0;
      r_w   <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
      r_o   <= '0;
      r_t   <= '0;
      r_fin <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_k   <= cfg_k;
            r_w   <= cfg_w;
            r_err <= !w_cfg_ok;
            r_cnt <= '0;
          end
        end
        LOAD_F: begin
          if (w_f_hs) r_cnt <= w_f_end ? '0 : r_cnt + WW'(1);
        end
        LOAD_I: begin
          if (w_i_hs) r_cnt <= w_i_end ? '0 : r_cnt + WW'(1);
          if (w_i_end) begin
            r_o   <= '0;
            r_t   <= '0;
            r_fin <= 1'b0;
          end
        end
        STREAM: begin
          if (w_load) begin
            if (w_t_last) begin
              r_t <= '0;
              if (w_o_last) r_fin <= 1'b1;
              else          r_o   <= r_o + WW'(1);
            end else begin
              r_t <= r_t + KW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // registered PE operand stage, held stable while stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pe_valid <= 1'b0;
      r_pe_ifmap <= '0;
      r_pe_fltr  <= '0;
      r_pe_first <= 1'b0;
      r_pe_last  <= 1'b0;
    end else if (w_load) begin
      r_pe_valid <= 1'b1;
      r_pe_ifmap <= w_irdata;
      r_pe_fltr  <= w_frdata;
      r_pe_first <= (r_t == '0);
      r_pe_last  <= w_t_last;
    end else if (w_out_hs) begin
      r_pe_valid <= 1'b0;
    end
  end

  assign pe_valid = r_pe_valid;
  assign pe_ifmap = r_pe_ifmap;
  assign pe_fltr  = r_pe_fltr;
  assign pe_first = r_pe_first;
  assign pe_last  = r_pe_last;

endmodule
